// File: rtl/skid_pipe_bank.sv
// Two-entry skid bank between pipeline stages: main entry drives out_*, skid catches overflow.
// Latency: 1 cycle from accept to out_valid; in_ready is registered (no out_ready->in_ready path).
module skid_pipe_bank #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Declaration initializers make the power-up state match the reset state.
    state_t             r_state     = ST_EMPTY;
    logic               r_in_rdy    = 1'b1;
    logic               r_main_vld  = 1'b0;
    logic [DATA_W-1:0]  r_main_dat  = '0;
    logic [TAG_W-1:0]   r_main_tag  = '0;
    logic               r_skid_vld  = 1'b0;
    logic [DATA_W-1:0]  r_skid_dat  = '0;
    logic [TAG_W-1:0]   r_skid_tag  = '0;
    logic [CNT_W-1:0]   r_stall_cnt = '0;

    logic w_acc;
    logic w_con;
    logic w_stall;

    assign w_acc   = in_valid && r_in_rdy;
    assign w_con   = r_main_vld && out_ready;
    assign w_stall = r_main_vld && !out_ready;

    assign in_ready  = r_in_rdy;
    assign out_valid = r_main_vld;
    assign out_data  = r_main_dat;
    assign out_tag   = r_main_tag;
    assign occupancy = {r_skid_vld, r_main_vld & ~r_skid_vld};
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_in_rdy    <= 1'b1;
            r_main_vld  <= 1'b0;
            r_main_dat  <= '0;
            r_main_tag  <= '0;
            r_skid_vld  <= 1'b0;
            r_skid_dat  <= '0;
            r_skid_tag  <= '0;
            r_stall_cnt <= '0;
        end else begin
            // Stall counting continues through flush; only reset clears it.
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

            if (flush) begin
                r_state    <= ST_EMPTY;
                r_in_rdy   <= 1'b1;
                r_main_vld <= 1'b0;
                r_main_dat <= '0;
                r_main_tag <= '0;
                r_skid_vld <= 1'b0;
                r_skid_dat <= '0;
                r_skid_tag <= '0;
            end else begin
                case (r_state)
                    ST_EMPTY: begin
                        if (w_acc) begin
                            r_state    <= ST_ONE;
                            r_main_vld <= 1'b1;
                            r_main_dat <= in_data;
                            r_main_tag <= in_tag;
                        end
                    end
                    ST_ONE: begin
                        if (w_acc && w_con) begin
                            r_main_dat <= in_data;
                            r_main_tag <= in_tag;
                        end else if (w_acc) begin
                            r_state    <= ST_FULL;
                            r_in_rdy   <= 1'b0;
                            r_skid_vld <= 1'b1;
                            r_skid_dat <= in_data;
                            r_skid_tag <= in_tag;
                        end else if (w_con) begin
                            r_state    <= ST_EMPTY;
                            r_main_vld <= 1'b0;
                        end
                    end
                    ST_FULL: begin
                        // in_ready is low here, so the only event is a consume.
                        if (w_con) begin
                            r_state    <= ST_ONE;
                            r_in_rdy   <= 1'b1;
                            r_main_dat <= r_skid_dat;
                            r_main_tag <= r_skid_tag;
                            r_skid_vld <= 1'b0;
                        end
                    end
                    default: begin
                        r_state    <= ST_EMPTY;
                        r_in_rdy   <= 1'b1;
                        r_main_vld <= 1'b0;
                        r_skid_vld <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_skid_pipe_bank.sv
// Directed bench for skid_pipe_bank (CNT_W=4) followed by a random run against a 2-deep queue model.
module tb_skid_pipe_bank;

    localparam int DATA_W = 64;
    localparam int TAG_W  = 4;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    skid_pipe_bank #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [63:0] d, input logic [3:0] t);
        in_valid = 1'b1;
        in_data  = d;
        in_tag   = t;
    endtask

    // Random-phase model state
    logic [63:0] q_dat[$];
    logic [3:0]  q_tag[$];
    int          m_stall;
    logic        r_in_v, r_out_r;

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_tag = '0;

        // Power-up state before any reset
        #1;
        chk("pwrup_out_valid", 64'(out_valid), 64'd0);
        chk("pwrup_in_ready",  64'(in_ready),  64'd1);
        chk("pwrup_occ",       64'(occupancy), 64'd0);
        chk("pwrup_stall",     64'(stall_cnt), 64'd0);

        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  out_data,       64'd0);
        chk("rst_out_tag",   64'(out_tag),   64'd0);
        chk("rst_occ",       64'(occupancy), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);

        // Streaming
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            offer(64'h11 * i, 4'(i));
            tick();
            chk("strm_out_valid", 64'(out_valid), 64'd1);
            chk("strm_out_data",  out_data,       64'h11 * i);
            chk("strm_out_tag",   64'(out_tag),   64'(i));
            chk("strm_occ",       64'(occupancy), 64'd1);
            chk("strm_in_ready",  64'(in_ready),  64'd1);
        end
        in_valid = 1'b0; tick();
        chk("strm_drain_valid", 64'(out_valid), 64'd0);
        chk("strm_stall",       64'(stall_cnt), 64'd0);

        // Backpressure
        out_ready = 1'b0;
        offer(64'hA, 4'd5); tick();
        chk("bp_occ1",      64'(occupancy), 64'd1);
        chk("bp_data1",     out_data,       64'hA);
        chk("bp_in_ready1", 64'(in_ready),  64'd1);
        offer(64'hB, 4'd6); tick();
        chk("bp_occ2",      64'(occupancy), 64'd2);
        chk("bp_in_ready2", 64'(in_ready),  64'd0);
        chk("bp_data2",     out_data,       64'hA);
        chk("bp_stall1",    64'(stall_cnt), 64'd1);
        offer(64'hD, 4'd9); tick();  // ignored: in_ready low
        chk("bp_full_occ",  64'(occupancy), 64'd2);
        chk("bp_full_data", out_data,       64'hA);
        chk("bp_full_tag",  64'(out_tag),   64'd5);
        chk("bp_stall2",    64'(stall_cnt), 64'd2);
        in_valid = 1'b0; out_ready = 1'b1; tick();
        chk("bp_pop_data",  out_data,       64'hB);
        chk("bp_pop_tag",   64'(out_tag),   64'd6);
        chk("bp_pop_occ",   64'(occupancy), 64'd1);
        chk("bp_pop_rdy",   64'(in_ready),  64'd1);
        chk("bp_pop_stall", 64'(stall_cnt), 64'd2);
        tick();
        chk("bp_empty_valid", 64'(out_valid), 64'd0);

        // Flush collision
        out_ready = 1'b0;
        offer(64'hA, 4'd5); tick();
        offer(64'hB, 4'd6); tick();
        chk("fl_pre_occ", 64'(occupancy), 64'd2);
        flush = 1'b1; out_ready = 1'b1; offer(64'hC, 4'd7); tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_occ",      64'(occupancy), 64'd0);
        chk("fl_valid",    64'(out_valid), 64'd0);
        chk("fl_data",     out_data,       64'd0);
        chk("fl_tag",      64'(out_tag),   64'd0);
        chk("fl_in_ready", 64'(in_ready),  64'd1);
        chk("fl_stall",    64'(stall_cnt), 64'd3);
        tick();
        chk("fl_no_c_valid", 64'(out_valid), 64'd0);

        // Stall saturation
        out_ready = 1'b0;
        offer(64'hE, 4'd8); tick(); in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall",  64'(stall_cnt), 64'd15);
        chk("sat_data",   out_data,       64'hE);
        tick();
        chk("sat_hold",   64'(stall_cnt), 64'd15);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("sat_rst_stall", 64'(stall_cnt), 64'd0);

        // Reset mid-operation
        offer(64'hA, 4'd5); tick();
        offer(64'hB, 4'd6); tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("rmo_pre_stall", 64'(stall_cnt), 64'd7);
        chk("rmo_pre_occ",   64'(occupancy), 64'd2);
        reset = 1'b1; offer(64'hF, 4'd3); tick();
        reset = 1'b0; in_valid = 1'b0;
        chk("rmo_occ",      64'(occupancy), 64'd0);
        chk("rmo_stall",    64'(stall_cnt), 64'd0);
        chk("rmo_in_ready", 64'(in_ready),  64'd1);
        chk("rmo_valid",    64'(out_valid), 64'd0);
        tick();
        chk("rmo_discard",  64'(out_valid), 64'd0);

        // Random traffic against a 2-deep queue model
        m_stall = 0;
        for (int c = 0; c < 10000; c++) begin
            r_in_v  = ($urandom_range(0, 3) != 0);
            r_out_r = ($urandom_range(0, 2) != 0);
            in_valid  = r_in_v;
            out_ready = r_out_r;
            in_data   = {$urandom, $urandom};
            in_tag    = 4'($urandom);
            chk("rnd_in_ready",  64'(in_ready),  64'(q_dat.size() != 2));
            chk("rnd_out_valid", 64'(out_valid), 64'(q_dat.size() != 0));
            chk("rnd_occ",       64'(occupancy), 64'(q_dat.size()));
            chk("rnd_stall",     64'(stall_cnt), 64'(m_stall));
            if (q_dat.size() != 0) begin
                chk("rnd_out_data", out_data,     q_dat[0]);
                chk("rnd_out_tag",  64'(out_tag), 64'(q_tag[0]));
            end
            begin
                logic [63:0] d_in;
                logic [3:0]  t_in;
                logic        acc;
                d_in = in_data;
                t_in = in_tag;
                acc  = r_in_v && (q_dat.size() != 2);
                if (q_dat.size() != 0) begin
                    if (r_out_r) begin
                        void'(q_dat.pop_front());
                        void'(q_tag.pop_front());
                    end else if (m_stall < 15) begin
                        m_stall++;
                    end
                end
                if (acc) begin
                    q_dat.push_back(d_in);
                    q_tag.push_back(t_in);
                end
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/skid_pipe_bank.md
SKID_PIPE_BANK -- requirements
Module: skid_pipe_bank

Interface
REQ-001 Parameters (name, default, meaning):
- DATA_W, 64, payload width (instruction, mode, ALU result and bus fields, concatenated by the instantiating stage).
- TAG_W, 4, ROB tag width.
- CNT_W, 16, stall-counter width.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, clock; all state updates on posedge.
- reset, in, 1, synchronous, active-high reset.
- flush, in, 1, synchronous squash of all held entries.
- in_valid, in, 1, upstream stage offers an entry.
- in_ready, out, 1, bank can accept an entry this cycle.
- in_data, in, DATA_W, upstream payload.
- in_tag, in, TAG_W, upstream ROB tag.
- out_valid, out, 1, bank presents an entry downstream.
- out_ready, in, 1, downstream consumes the presented entry.
- out_data, out, DATA_W, presented payload.
- out_tag, out, TAG_W, presented ROB tag.
- occupancy, out, 2, number of held entries (0..2).
- stall_cnt, out, CNT_W, saturating count of stalled cycles.

Function
REQ-003 The bank SHALL hold two entries: main (drives out_*) and skid (overflow). Each entry has a valid bit, payload and tag.
REQ-004 States SHALL be EMPTY (no entry held), ONE (main only) and FULL (main and skid). occupancy SHALL equal 0, 1 or 2 respectively.
REQ-005 in_ready SHALL be registered and equal to (state != FULL). It SHALL have no combinational path from out_ready.
REQ-006 An input is accepted when in_valid && in_ready. An output is consumed when out_valid && out_ready. out_valid SHALL equal (state != EMPTY).
REQ-007 EMPTY + accept -> ONE; main is loaded with in_data/in_tag. Latency from accept to out_valid is 1 cycle.
REQ-008 ONE transitions:
- accept and consume -> ONE; main is reloaded from the input.
- accept only -> FULL; skid is loaded.
- consume only -> EMPTY.
- neither -> ONE; main is held.
REQ-009 FULL transitions:
- consume -> ONE; skid moves to main and the skid valid bit clears.
- no consume -> FULL; all held.
- No accept is possible in FULL.
REQ-010 out_data and out_tag SHALL remain stable while out_valid && !out_ready.
REQ-011 Entries SHALL leave in arrival order. No entry SHALL be dropped or duplicated.
REQ-012 flush SHALL force EMPTY on the next edge and zero all payloads and tags.
- flush overrides any simultaneous accept or consume; the input offered in the flush cycle is discarded.
- in_ready SHALL be 1 in the cycle after flush.
REQ-013 stall_cnt SHALL increment by 1 on each cycle with out_valid && !out_ready and SHALL saturate at 2^CNT_W-1. flush does not clear it.
REQ-014 in_valid while !in_ready SHALL have no effect on state.

Reset
REQ-015 While reset=1 at a posedge the bank SHALL enter EMPTY and set:
- main/skid payloads and tags = 0
- out_valid = 0, out_data = 0, out_tag = 0
- occupancy = 0, stall_cnt = 0
- in_ready = 1
REQ-016 reset SHALL take priority over flush, accept and consume. Held entries are discarded when reset is asserted mid-operation.
REQ-017 At time zero (power-up, before any reset) the initial state SHALL equal the reset state.

Verification
REQ-018 Streaming: out_ready=1; offer data 0x11, 0x22, 0x33 with tags 1, 2, 3 on consecutive cycles -> same values appear on out_* one cycle later each, in_ready stays 1, occupancy=1 throughout.
REQ-019 Backpressure: out_ready=0; offer 0xA (tag 5) then 0xB (tag 6) -> occupancy 1 then 2, in_ready=0. Raise out_ready -> 0xA then 0xB emerge, and in_ready=1 one cycle after the first consume.
REQ-020 Flush collision: FULL with 0xA/0xB, assert flush together with in_valid (0xC) and out_ready=1 -> next cycle EMPTY, out_valid=0, out_data=0, 0xC never appears.
REQ-021 Stall saturation: CNT_W=4, hold one entry with out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays 15.
REQ-022 Reset mid-operation: FULL with stall_cnt=7, assert reset with in_valid=1 -> next cycle occupancy=0, stall_cnt=0, in_ready=1, offered input discarded.
REQ-023 Random: random in_valid/out_ready over 10k cycles against a 2-deep FIFO model -> identical order, no loss or duplication, REQ-010 stability never violated.
